alu_issue_ctrl: RTL and testbench

Execute-stage issue controller that drives the combinational ALU. It accepts one decoded operation per handshake and translates ALUOp/funct into the 4-bit ALU control code. It presents the operands to the ALU and captures the ALU result into a registered response. When enabled, multiply and divide run on an internal iterative unit instead of the ALU's combinational `*` and `/` paths. It sits between the decode/register-read stage and the ALU/writeback path.

---
 rtl/alu_pkg.sv | 62 ++++++
 rtl/muldiv_iter.sv | 90 +++++++++
 rtl/alu_issue_ctrl.sv | 133 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage issue controller: ALU codes, ALUOp/funct
// encodings, controller state enum and the ALUOp/funct -> ALU code decoder.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_MUL = 4'd8;
  localparam logic [3:0] ALU_DIV = 4'd9;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [3:0] ALU_NOP = 4'd15;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011000;
  localparam logic [5:0] FN_DIV = 6'b011010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MUL,
    ST_DIV,
    ST_RESP
  } state_e;

  // Unknown R-type funct yields ALU_NOP; the ALU treats that as a zero result.
  function automatic logic [3:0] alu_code(input logic [1:0] op, input logic [5:0] fn);
    logic [3:0] c;
    c = ALU_NOP;
    case (op)
      ALUOP_ADD: c = ALU_ADD;
      ALUOP_SUB: c = ALU_SUB;
      ALUOP_OR:  c = ALU_OR;
      default: begin
        case (fn)
          FN_ADD:  c = ALU_ADD;
          FN_SUB:  c = ALU_SUB;
          FN_AND:  c = ALU_AND;
          FN_OR:   c = ALU_OR;
          FN_NOR:  c = ALU_NOR;
          FN_SLT:  c = ALU_SLT;
          FN_MUL:  c = ALU_MUL;
          FN_DIV:  c = ALU_DIV;
          default: c = ALU_NOP;
        endcase
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiplier (shift-add) / restoring divider, one bit per cycle.
// Used by alu_issue_ctrl only when ALU_ISSUE_MULDIV_EN is defined.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             dbz_o
);

  localparam int CNT_W = $clog2(ITER) + 1;

  // r: product accumulator / partial remainder
  // s: shifted multiplicand / divisor
  // t: remaining multiplier bits / dividend shifting into quotient
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d, s_q, s_d, t_q, t_d;
  logic             div_q, div_d, dbz_q, dbz_d;
  logic [WIDTH:0]   rem_sh, diff;

  always_comb begin
    cnt_d  = cnt_q;
    r_d    = r_q;
    s_d    = s_q;
    t_d    = t_q;
    div_d  = div_q;
    dbz_d  = dbz_q;
    rem_sh = {r_q, t_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, s_q};
    if (start_i) begin
      cnt_d = CNT_W'(ITER);
      div_d = is_div_i;
      dbz_d = is_div_i && (b_i == '0);
      r_d   = '0;
      s_d   = b_i;
      t_d   = a_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (div_q) begin
        // A zero divisor never underflows, so the quotient fills with ones.
        if (!diff[WIDTH]) begin
          r_d = diff[WIDTH-1:0];
          t_d = {t_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = rem_sh[WIDTH-1:0];
          t_d = {t_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        r_d = r_q + (t_q[0] ? s_q : '0);
        s_d = s_q << 1;
        t_d = t_q >> 1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      r_q   <= '0;
      s_q   <= '0;
      t_q   <= '0;
      div_q <= 1'b0;
      dbz_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      r_q   <= r_d;
      s_q   <= s_d;
      t_q   <= t_d;
      div_q <= div_d;
      dbz_q <= dbz_d;
    end
  end

  // result_o is the outcome of the step taken in the done cycle.
  assign busy_o   = (cnt_q != '0);
  assign done_o   = (cnt_q == CNT_W'(1));
  assign result_o = div_q ? t_d : r_d;
  assign dbz_o    = dbz_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller: decodes ALUOp/funct, drives the ALU and registers
// its result. Define ALU_ISSUE_MULDIV_EN to run mul/div on the iterative unit.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [3:0]       alu_ctr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             illegal,
  output logic             div_by_zero
);

  state_e           state_q;
  logic [3:0]       ctr_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             zero_q, vld_q, ill_q, ill_pend_q;
  logic [3:0]       code;
  logic             code_ill;
  logic             xfer;

  assign code     = alu_code(alu_op, funct);
  assign code_ill = (alu_op == ALUOP_RTYPE) && (code == ALU_NOP);
  assign xfer     = in_valid && (state_q == ST_IDLE);

`ifdef ALU_ISSUE_MULDIV_EN
  logic             md_busy, md_done, md_dbz, dbz_q;
  logic [WIDTH-1:0] md_res;

  muldiv_iter #(.WIDTH(WIDTH), .ITER(ITER)) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .start_i  (xfer && ((code == ALU_MUL) || (code == ALU_DIV))),
    .is_div_i (code == ALU_DIV),
    .a_i      (op_a),
    .b_i      (op_b),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .result_o (md_res),
    .dbz_o    (md_dbz)
  );

  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ctr_q      <= ALU_NOP;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      zero_q     <= 1'b1;
      vld_q      <= 1'b0;
      ill_q      <= 1'b0;
      ill_pend_q <= 1'b0;
`ifdef ALU_ISSUE_MULDIV_EN
      dbz_q      <= 1'b0;
`endif
    end else begin
      vld_q <= 1'b0;
      ill_q <= 1'b0;
`ifdef ALU_ISSUE_MULDIV_EN
      dbz_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (xfer) begin
            ctr_q      <= code;
            a_q        <= op_a;
            b_q        <= op_b;
            ill_pend_q <= code_ill;
`ifdef ALU_ISSUE_MULDIV_EN
            if (code == ALU_MUL)      state_q <= ST_MUL;
            else if (code == ALU_DIV) state_q <= ST_DIV;
            else                      state_q <= ST_EXEC;
`else
            state_q <= ST_EXEC;
`endif
          end
        end
        ST_EXEC: begin
          res_q   <= alu_result;
          zero_q  <= (alu_result == '0);
          vld_q   <= 1'b1;
          ill_q   <= ill_pend_q;
          state_q <= ST_RESP;
        end
`ifdef ALU_ISSUE_MULDIV_EN
        ST_MUL, ST_DIV: begin
          if (md_done) begin
            res_q   <= md_res;
            zero_q  <= (md_res == '0);
            vld_q   <= 1'b1;
            dbz_q   <= md_dbz;
            state_q <= ST_RESP;
          end else if (!md_busy) begin
            state_q <= ST_IDLE;
          end
        end
`endif
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign alu_ctr   = ctr_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign res_valid = vld_q;
  assign res_data  = res_q;
  assign res_zero  = zero_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed cases plus random operations
// against a behavioural model of the controller and a model combinational ALU.
module tb_alu_issue_ctrl;

  localparam int W  = 32;
  localparam int IT = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready;
  logic [1:0]    alu_op;
  logic [5:0]    funct;
  logic [W-1:0]  op_a, op_b, alu_a, alu_b, alu_result, res_data;
  logic [3:0]    alu_ctr;
  logic          res_valid, res_zero, illegal, div_by_zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(W), .ITER(IT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .op_a(op_a), .op_b(op_b),
    .alu_ctr(alu_ctr), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .res_valid(res_valid), .res_data(res_data), .res_zero(res_zero),
    .illegal(illegal), .div_by_zero(div_by_zero)
  );

  // Environment: the combinational ALU this controller drives.
  function automatic logic [W-1:0] alu_f(input logic [3:0] c, input logic [W-1:0] a, b);
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return {31'b0, $signed(a) < $signed(b)};
      4'd8:    return a * b;
      4'd9:    return (b == 0) ? '1 : a / b;
      4'd12:   return ~(a | b);
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_ctr, alu_a, alu_b);

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: what the operation means, its code, flags and response latency.
  task automatic ref_op(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] a, b,
                        output logic [3:0] code, output logic [W-1:0] res,
                        output bit ill, output bit dbz, output int lat);
    bit md = 0;
    ill = 0; dbz = 0;
    case (op)
      2'b00: begin code = 2; res = a + b; end
      2'b01: begin code = 6; res = a - b; end
      2'b11: begin code = 1; res = a | b; end
      default: begin
        case (fn)
          6'b100000: begin code = 2;  res = a + b; end
          6'b100010: begin code = 6;  res = a - b; end
          6'b100100: begin code = 0;  res = a & b; end
          6'b100101: begin code = 1;  res = a | b; end
          6'b100111: begin code = 12; res = ~(a | b); end
          6'b101010: begin code = 7;  res = ($signed(a) < $signed(b)) ? 1 : 0; end
          6'b011000: begin code = 8;  res = W'((64'(a) * 64'(b)) & 64'hFFFF_FFFF); md = 1; end
          6'b011010: begin code = 9;  res = (b == 0) ? 32'hFFFF_FFFF : a / b; md = 1;
`ifdef ALU_ISSUE_MULDIV_EN
                           dbz = (b == 0);
`endif
                     end
          default:   begin code = 15; res = 0; ill = 1; end
        endcase
      end
    endcase
`ifdef ALU_ISSUE_MULDIV_EN
    lat = md ? IT + 1 : 2;
`else
    lat = 2;
`endif
  endtask

  task automatic do_op(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] a, b,
                       input bit junk);
    logic [3:0] e_code; logic [W-1:0] e_res; bit e_ill, e_dbz; int e_lat, lat;
    ref_op(op, fn, a, b, e_code, e_res, e_ill, e_dbz, e_lat);
    @(negedge clk);
    chk("ready_before", in_ready, 1);
    in_valid = 1; alu_op = op; funct = fn; op_a = a; op_b = b;
    @(negedge clk);
    lat = 1;
    chk("alu_ctr", alu_ctr, e_code);
    chk("ready_busy", in_ready, 0);
    in_valid = junk;
    if (junk) begin
      alu_op = 2'($urandom); funct = 6'($urandom); op_a = $urandom; op_b = $urandom;
    end
    while (!res_valid && lat < 100) begin
      @(negedge clk);
      lat++;
      if (!res_valid) chk("ready_wait", in_ready, 0);
    end
    chk("latency", lat, e_lat);
    chk("res_data", res_data, e_res);
    chk("res_zero", res_zero, e_res == 0);
    chk("illegal", illegal, e_ill);
    chk("div_by_zero", div_by_zero, e_dbz);
    chk("alu_a_held", alu_a, a);
    chk("alu_b_held", alu_b, b);
    in_valid = 0;
    @(negedge clk);
    chk("valid_pulse", res_valid, 0);
    chk("illegal_pulse", illegal, 0);
    chk("data_held", res_data, e_res);
    chk("ready_again", in_ready, 1);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_ready"}, in_ready, 1);
    chk({pfx, "_ctr"}, alu_ctr, 15);
    chk({pfx, "_a"}, alu_a, 0);
    chk({pfx, "_b"}, alu_b, 0);
    chk({pfx, "_data"}, res_data, 0);
    chk({pfx, "_zero"}, res_zero, 1);
    chk({pfx, "_valid"}, res_valid, 0);
    chk({pfx, "_illegal"}, illegal, 0);
    chk({pfx, "_dbz"}, div_by_zero, 0);
  endtask

  logic [5:0] fn_tab [10] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111,
                               6'b101010, 6'b011000, 6'b011010, 6'b111111, 6'b000000};

  initial begin
    int seen;
    reset = 1; in_valid = 0; alu_op = 0; funct = 0; op_a = 0; op_b = 0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 0;
    @(negedge clk);
    chk_reset_vals("post_rst");

    do_op(2'b10, 6'b100000, 5, 7, 0);
    do_op(2'b01, 6'b000000, 9, 9, 0);
    do_op(2'b10, 6'b011000, 32'h10000, 32'h10001, 1);
    do_op(2'b10, 6'b011010, 100, 7, 1);
    do_op(2'b10, 6'b011010, 100, 0, 0);
    do_op(2'b10, 6'b111111, 3, 4, 0);
    do_op(2'b11, 6'b000000, 32'hF0, 32'h0F, 0);
    do_op(2'b10, 6'b101010, 32'hFFFF_FFFF, 1, 0);

    // Reset in the middle of a divide: immediate reset values, no response.
    @(negedge clk);
    in_valid = 1; alu_op = 2'b10; funct = 6'b011010; op_a = 1000; op_b = 3;
    @(negedge clk);
    in_valid = 0;
    repeat (9) @(negedge clk);
    reset = 1;
    #1;
    chk_reset_vals("mid_rst");
    @(negedge clk);
    reset = 0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    chk("no_resp_after_rst", seen, 0);
    do_op(2'b00, 6'b000000, 20, 22, 0);

    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
      rb = ($urandom_range(0, 4) == 0) ? '0 :
           ($urandom_range(0, 2) == 0) ? W'($urandom_range(1, 50)) : W'($urandom);
      do_op(2'($urandom), fn_tab[$urandom_range(0, 9)], ra, rb, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
